// File: rtl/uart_rx_fifo.sv
// Buffered 8N1 UART receiver: 8x oversampled start/data/stop recovery feeding a
// first-word-fall-through byte FIFO, read through a reg_state/reg_dat register pair.
module uart_rx_fifo #(
    parameter int UART_CLK   = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    input  logic        reg_state_we,
    input  logic        reg_state_re,
    input  logic [31:0] reg_state_di,
    output logic [31:0] reg_state_do,
    output logic        reg_state_wait,
    input  logic        reg_dat_re,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait
);

    localparam int UART_DIV = UART_CLK / (BAUD_RATE * 8);
    localparam int CW       = $clog2(UART_DIV + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int PW       = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [CW-1:0] div_q;
    logic          tick;
    logic [1:0]    sync_q;
    logic          rx_s;

    state_t        state_q;
    logic [2:0]    sub_q;
    logic [2:0]    bitn_q;
    logic [7:0]    shreg_q;
    logic          push_q;
    logic          frame_err_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [PW-1:0] count;
    logic          full, empty, pop, push_ok;
    logic          overrun_q, overrun_d;
    logic [31:0]   count_ext;
    logic          unused_bits;

    assign reg_state_wait = 1'b0;
    assign reg_dat_wait   = 1'b0;
    assign unused_bits    = ^{reg_state_re, reg_state_di[31:4], reg_state_di[1:0]};

    // ------------------------------------------------------------------
    // Oversample tick and input synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q <= '0;
        end else if (div_q == CW'(UART_DIV - 1)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ser_rx};
        end
    end

    assign rx_s = sync_q[1];

    // ------------------------------------------------------------------
    // Frame FSM. sub counts ticks within a bit; the start bit is checked
    // half a bit in, after which every 8th tick lands mid-bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            sub_q       <= '0;
            bitn_q      <= '0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (reg_state_we && reg_state_di[3]) begin
                frame_err_q <= 1'b0;
            end
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state_q <= S_START;
                            sub_q   <= '0;
                        end
                    end
                    S_START: begin
                        if (sub_q == 3'd3) begin
                            if (rx_s) begin
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_DATA;
                                sub_q   <= '0;
                                bitn_q  <= '0;
                            end
                        end else begin
                            sub_q <= sub_q + 3'd1;
                        end
                    end
                    S_DATA: begin
                        sub_q <= sub_q + 3'd1;
                        if (sub_q == 3'd7) begin
                            shreg_q <= {rx_s, shreg_q[7:1]};
                            bitn_q  <= bitn_q + 3'd1;
                            if (bitn_q == 3'd7) begin
                                state_q <= S_STOP;
                            end
                        end
                    end
                    S_STOP: begin
                        sub_q <= sub_q + 3'd1;
                        if (sub_q == 3'd7) begin
                            if (rx_s) begin
                                push_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                // Set after the clear above so a same-cycle set wins.
                                frame_err_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO. Pointers carry one extra bit so full and empty differ.
    // ------------------------------------------------------------------
    assign count   = wp_q - rp_q;
    assign full    = (count == PW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = reg_dat_re && !empty;
    assign push_ok = push_q && (!full || pop);

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        overrun_d = overrun_q;
        if (push_ok) begin
            wp_d = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
        if (reg_state_we && reg_state_di[2]) begin
            overrun_d = 1'b0;
        end
        if (push_q && !push_ok) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_q      <= '0;
            rp_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            overrun_q <= overrun_d;
        end
    end

    // When full with a same-cycle pop, wp aliases the slot being vacated.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wp_q[AW-1:0]] <= shreg_q;
        end
    end

    // ------------------------------------------------------------------
    // Register views
    // ------------------------------------------------------------------
    assign count_ext    = 32'(count);
    assign reg_dat_do   = {24'h0, empty ? 8'h00 : mem_q[rp_q[AW-1:0]]};
    assign reg_state_do = {16'h0, count_ext[7:0], 4'h0,
                           frame_err_q, overrun_q, full, !empty};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven on ser_rx, expected bytes
// queued at send time and checked by a monitor on every data-register pop.
module tb_uart_rx_fifo;

    localparam int BIT = 104;   // 13 clk per tick x 8 ticks per bit
    localparam int DIV = 13;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ser_rx = 1'b1;
    logic        reg_state_we = 1'b0;
    logic        reg_state_re = 1'b0;
    logic [31:0] reg_state_di = 32'h0;
    logic [31:0] reg_state_do;
    logic        reg_state_wait;
    logic        reg_dat_re = 1'b0;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    int          cyc = 0;
    int          ferr_rises = 0;
    logic        ferr_prev = 1'b0;
    int          push_k = 1;

    uart_rx_fifo #(
        .UART_CLK  (12000000),
        .BAUD_RATE (115200),
        .FIFO_DEPTH(16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ser_rx        (ser_rx),
        .reg_state_we  (reg_state_we),
        .reg_state_re  (reg_state_re),
        .reg_state_di  (reg_state_di),
        .reg_state_do  (reg_state_do),
        .reg_state_wait(reg_state_wait),
        .reg_dat_re    (reg_dat_re),
        .reg_dat_do    (reg_dat_do),
        .reg_dat_wait  (reg_dat_wait)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reg_state_do[3] && !ferr_prev) ferr_rises = ferr_rises + 1;
        ferr_prev = reg_state_do[3];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, got, want);
        end else begin
            $display("ok   %s: 0x%08h", name, got);
        end
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && reg_dat_re) begin
                if (reg_state_do[0]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pop_unexpected: got=0x%02h want=<none>", reg_dat_do[7:0]);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("pop_data", reg_dat_do, {24'h0, e});
                    end
                end else if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL pop_missing: got=<empty> want=0x%02h", e);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic line(input logic v, input int n);
        ser_rx = v;
        step(n);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic keep);
        if (keep) exp_q.push_back(b);
        line(1'b0, BIT);
        for (int i = 0; i < 8; i++) line(b[i], BIT);
        line(stop, BIT);
        ser_rx = 1'b1;
    endtask

    task automatic pop();
        reg_dat_re = 1'b1;
        step(1);
        reg_dat_re = 1'b0;
    endtask

    task automatic write_state(input logic [31:0] v);
        reg_state_di = v;
        reg_state_we = 1'b1;
        step(1);
        reg_state_we = 1'b0;
        reg_state_di = 32'h0;
    endtask

    task automatic align();
        step(1);
        while (cyc % DIV != 0) step(1);
    endtask

    initial begin
        int f0;
        int found;

        // Reset and idle
        step(5);
        check("reset_state", reg_state_do, 32'h0);
        check("reset_dat", reg_dat_do, 32'h0);
        check("wait_tied", {30'h0, reg_state_wait, reg_dat_wait}, 32'h0);
        resetn = 1'b1;
        step(20);
        check("idle_state", reg_state_do, 32'h0);

        // Single byte
        send(8'h55, 1'b1, 1'b1);
        step(4);
        check("t1_state", reg_state_do, 32'h0000_0101);
        check("t1_dat", reg_dat_do, 32'h0000_0055);
        pop();
        check("t1_popped", reg_state_do, 32'h0);

        // Back-to-back bytes
        send(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        send(8'hA5, 1'b1, 1'b1);
        step(4);
        check("t2_state", reg_state_do, 32'h0000_0301);
        pop(); pop(); pop();
        check("t2_drained", reg_state_do, 32'h0);
        pop();
        check("empty_pop", reg_state_do, 32'h0);

        // Start-bit glitch, then a good byte; the push edge is recorded
        line(1'b0, 26);
        line(1'b1, 3 * BIT);
        check("glitch_state", reg_state_do, 32'h0);
        align();
        found = 0;
        fork
            send(8'h3C, 1'b1, 1'b1);
            begin
                for (int i = 1; i <= 11 * BIT && found == 0; i++) begin
                    step(1);
                    if (reg_state_do[15:8] == 8'd1) begin
                        found  = 1;
                        push_k = i;
                    end
                end
            end
        join
        check("t3_push_seen", found, 1);
        step(4);
        check("t3_state", reg_state_do, 32'h0000_0101);
        pop();

        // Frame error followed by a break
        f0 = ferr_rises;
        send(8'hA5, 1'b0, 1'b0);
        line(1'b0, 3 * BIT);
        line(1'b1, 2 * BIT);
        check("t4_state", reg_state_do, 32'h0000_0008);
        check("t4_ferr_once", ferr_rises - f0, 1);
        write_state(32'h0000_0008);
        check("t4_cleared", reg_state_do, 32'h0);
        send(8'h12, 1'b1, 1'b1);
        step(4);
        check("t4_next", reg_state_do, 32'h0000_0101);
        pop();

        // Overflow: 17 bytes, the last is dropped
        for (int b = 0; b < 17; b++) send(8'(b), 1'b1, b < 16);
        step(4);
        check("t5_overrun", reg_state_do, 32'h0000_1007);
        write_state(32'h0000_0004);
        check("t5_ovr_clear", reg_state_do, 32'h0000_1003);

        // Full FIFO with a pop on the exact push cycle
        align();
        fork
            send(8'h11, 1'b1, 1'b1);
            begin
                step(push_k - 1);
                reg_dat_re = 1'b1;
                step(1);
                reg_dat_re = 1'b0;
            end
        join
        step(4);
        check("t5_pop_push", reg_state_do, 32'h0000_1003);
        for (int i = 0; i < 16; i++) pop();
        check("t5_drained", reg_state_do, 32'h0);

        // Reset mid-frame clears FIFO contents and the partial frame
        send(8'h99, 1'b1, 1'b0);
        step(4);
        check("t6_pre", reg_state_do, 32'h0000_0101);
        fork
            send(8'h81, 1'b1, 1'b0);
            begin
                step(8 * BIT + 30);
                resetn = 1'b0;
                step(3);
                check("t6_in_reset", reg_state_do, 32'h0);
                resetn = 1'b1;
            end
        join
        step(2 * BIT);
        check("t6_after", reg_state_do, 32'h0);
        check("t6_dat", reg_dat_do, 32'h0);
        send(8'h7E, 1'b1, 1'b1);
        step(4);
        check("t6_next", reg_state_do, 32'h0000_0101);
        pop();
        check("t6_drained", reg_state_do, 32'h0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
